// File: rtl/stdp_learn.sv
// Pair-based STDP engine: per-channel saturating spike timers drive LTP/LTD on a weight bank.
// Define STDP_TWO_LEVEL_EN to halve-window the step size (full step near, unit step far).
module stdp_learn #(
  parameter int unsigned NUM_PRE     = 4,
  parameter int unsigned TIME_W      = 8,
  parameter int unsigned WEIGHT_W    = 4,
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned LTP_STEP    = 2,
  parameter int unsigned LTD_STEP    = 1,
  parameter int unsigned INIT_WEIGHT = 8,
  localparam int unsigned AddrW      = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_PRE-1:0]           pre_spike,
  input  logic                         post_spike,
  input  logic                         learn_en,
  input  logic                         wr_en,
  input  logic [AddrW-1:0]             wr_addr,
  input  logic [WEIGHT_W-1:0]          wr_data,
  output logic [NUM_PRE*WEIGHT_W-1:0]  weights,
  output logic [NUM_PRE-1:0]           ltp_mask,
  output logic [NUM_PRE-1:0]           ltd_mask,
  output logic                         update_w_flag,
  output logic [TIME_W-1:0]            time_diff
);

  localparam logic [TIME_W-1:0]   TimeMax = {TIME_W{1'b1}};
  localparam logic [TIME_W-1:0]   WinT    = TIME_W'(WINDOW);
  localparam logic [WEIGHT_W:0]   WMax    = {1'b0, {WEIGHT_W{1'b1}}};
  localparam logic [WEIGHT_W:0]   LtpS    = (WEIGHT_W+1)'(LTP_STEP);
  localparam logic [WEIGHT_W:0]   LtdS    = (WEIGHT_W+1)'(LTD_STEP);
`ifdef STDP_TWO_LEVEL_EN
  localparam logic [TIME_W-1:0]   HalfT   = TIME_W'(WINDOW / 2);
  localparam logic [WEIGHT_W:0]   OneS    = (WEIGHT_W+1)'(1);
`endif

  logic [TIME_W-1:0]   pre_t_q [NUM_PRE];
  logic [TIME_W-1:0]   pre_t_d [NUM_PRE];
  logic [TIME_W-1:0]   post_t_q, post_t_d;
  logic [WEIGHT_W-1:0] weight_q [NUM_PRE];
  logic [WEIGHT_W-1:0] weight_d [NUM_PRE];
  logic [NUM_PRE-1:0]  ltp_mask_q, ltp_mask_d, ltd_mask_q, ltd_mask_d;
  logic                flag_q, flag_d;
  logic [TIME_W-1:0]   time_diff_q, time_diff_d;

  logic [NUM_PRE-1:0]  ltp, ltd;
  logic [TIME_W-1:0]   dt [NUM_PRE];
  logic [WEIGHT_W:0]   ltp_step [NUM_PRE];
  logic [WEIGHT_W:0]   ltd_step [NUM_PRE];
  logic [WEIGHT_W:0]   w_up [NUM_PRE];
  logic [WEIGHT_W:0]   w_dn [NUM_PRE];

  // Rule evaluation uses timer values held before this edge.
  always_comb begin
    for (int i = 0; i < NUM_PRE; i++) begin
      ltp[i] = post_spike && (pre_spike[i] || (pre_t_q[i] < WinT));
      ltd[i] = !ltp[i] && pre_spike[i] && (post_t_q < WinT);
      if (ltp[i]) dt[i] = pre_spike[i] ? '0 : pre_t_q[i];
      else        dt[i] = post_t_q;
`ifdef STDP_TWO_LEVEL_EN
      ltp_step[i] = (dt[i] < HalfT) ? LtpS : OneS;
      ltd_step[i] = (dt[i] < HalfT) ? LtdS : OneS;
`else
      ltp_step[i] = LtpS;
      ltd_step[i] = LtdS;
`endif
      w_up[i] = {1'b0, weight_q[i]} + ltp_step[i];
      w_dn[i] = {1'b0, weight_q[i]} - ltd_step[i];
    end
  end

  always_comb begin
    post_t_d    = post_spike ? '0 : ((post_t_q == TimeMax) ? post_t_q : post_t_q + 1'b1);
    time_diff_d = time_diff_q;
    ltp_mask_d  = learn_en ? ltp : '0;
    ltd_mask_d  = learn_en ? ltd : '0;
    flag_d      = learn_en && (|(ltp | ltd));
    for (int i = 0; i < NUM_PRE; i++) begin
      pre_t_d[i]  = pre_spike[i] ? '0 :
                    ((pre_t_q[i] == TimeMax) ? pre_t_q[i] : pre_t_q[i] + 1'b1);
      weight_d[i] = weight_q[i];
      if (learn_en && ltp[i]) begin
        weight_d[i] = (w_up[i] > WMax) ? WMax[WEIGHT_W-1:0] : w_up[i][WEIGHT_W-1:0];
      end else if (learn_en && ltd[i]) begin
        // Borrow out of the extended subtraction means the result went negative.
        weight_d[i] = w_dn[i][WEIGHT_W] ? '0 : w_dn[i][WEIGHT_W-1:0];
      end
      if (wr_en && (wr_addr == AddrW'(i))) weight_d[i] = wr_data;
    end
    // Descending scan so the lowest-index event channel wins.
    for (int i = NUM_PRE - 1; i >= 0; i--) begin
      if (learn_en && (ltp[i] || ltd[i])) time_diff_d = dt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PRE; i++) begin
        pre_t_q[i]  <= TimeMax;
        weight_q[i] <= WEIGHT_W'(INIT_WEIGHT);
      end
      post_t_q    <= TimeMax;
      ltp_mask_q  <= '0;
      ltd_mask_q  <= '0;
      flag_q      <= 1'b0;
      time_diff_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PRE; i++) begin
        pre_t_q[i]  <= pre_t_d[i];
        weight_q[i] <= weight_d[i];
      end
      post_t_q    <= post_t_d;
      ltp_mask_q  <= ltp_mask_d;
      ltd_mask_q  <= ltd_mask_d;
      flag_q      <= flag_d;
      time_diff_q <= time_diff_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PRE; i++) weights[i*WEIGHT_W +: WEIGHT_W] = weight_q[i];
  end

  assign ltp_mask      = ltp_mask_q;
  assign ltd_mask      = ltd_mask_q;
  assign update_w_flag = flag_q;
  assign time_diff     = time_diff_q;

endmodule

// File: tb/tb_stdp_learn.sv
// Scoreboard bench for stdp_learn (default build): directed spike pairs, expected updates queued.
module tb_stdp_learn;

  typedef struct packed {
    logic [3:0]  ltp;
    logic [3:0]  ltd;
    logic [7:0]  td;
    logic [15:0] w;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pre_spike;
  logic        post_spike;
  logic        learn_en;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [15:0] weights;
  logic [3:0]  ltp_mask;
  logic [3:0]  ltd_mask;
  logic        update_w_flag;
  logic [7:0]  time_diff;

  exp_t  sb_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  stdp_learn dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pre_spike     (pre_spike),
    .post_spike    (post_spike),
    .learn_en      (learn_en),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .weights       (weights),
    .ltp_mask      (ltp_mask),
    .ltd_mask      (ltd_mask),
    .update_w_flag (update_w_flag),
    .time_diff     (time_diff)
  );

  // Monitor: every update pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    if (rst_n && update_w_flag) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_update: got ltp=%b ltd=%b td=%0d w=%h, required no update",
                 ltp_mask, ltd_mask, time_diff, weights);
      end else begin
        e = sb_q.pop_front();
        n = name_q.pop_front();
        if ({ltp_mask, ltd_mask, time_diff, weights} !== e) begin
          errors++;
          $display("FAIL %s: got ltp=%b ltd=%b td=%0d w=%h, required ltp=%b ltd=%b td=%0d w=%h",
                   n, ltp_mask, ltd_mask, time_diff, weights, e.ltp, e.ltd, e.td, e.w);
        end
      end
    end
  end

  task automatic expect_upd(input string n, input logic [3:0] lp, input logic [3:0] ld,
                            input logic [7:0] td, input logic [15:0] w);
    exp_t e;
    e.ltp = lp; e.ltd = ld; e.td = td; e.w = w;
    sb_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spike(input logic [3:0] pre, input logic post);
    pre_spike  = pre;
    post_spike = post;
    idle(1);
    pre_spike  = '0;
    post_spike = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] w2;
    pre_spike = '0; post_spike = 1'b0; learn_en = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    do_reset();

    // Reset state, then a lone post spike with saturated timers.
    chk("reset_weights", 32'(weights), 32'h8888);
    chk("reset_masks", 32'({ltp_mask, ltd_mask, update_w_flag}), 32'h0);
    chk("reset_time_diff", 32'(time_diff), 32'h0);
    spike(4'b0000, 1'b1);
    idle(20);
    chk("lone_post_weights", 32'(weights), 32'h8888);

    // LTP on channel 1 with dt=2, five times: 10, 12, 14, 15, 15.
    expect_upd("ltp1_a", 4'b0010, 4'b0, 8'd2, 16'h88A8);
    expect_upd("ltp1_b", 4'b0010, 4'b0, 8'd2, 16'h88C8);
    expect_upd("ltp1_c", 4'b0010, 4'b0, 8'd2, 16'h88E8);
    expect_upd("ltp1_d", 4'b0010, 4'b0, 8'd2, 16'h88F8);
    expect_upd("ltp1_clip", 4'b0010, 4'b0, 8'd2, 16'h88F8);
    for (int j = 0; j < 5; j++) begin
      spike(4'b0010, 1'b0);
      idle(2);
      spike(4'b0000, 1'b1);
      idle(20);
    end

    // LTD on channel 2 with dt=4, ten times: 7 down to 0, then holding at 0.
    for (int j = 1; j <= 10; j++) begin
      w2 = (j >= 8) ? 4'h0 : 4'(8 - j);
      expect_upd("ltd2", 4'b0, 4'b0100, 8'd4, {4'h8, w2, 4'hF, 4'h8});
      spike(4'b0000, 1'b1);
      idle(4);
      spike(4'b0100, 1'b0);
      idle(20);
    end

    // Reset overrides a coincident write and spikes.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hF; pre_spike = 4'hF; post_spike = 1'b1;
    rst_n = 1'b0;
    idle(1);
    wr_en = 1'b0; pre_spike = '0; post_spike = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("midrst_weights", 32'(weights), 32'h8888);
    chk("midrst_time_diff", 32'(time_diff), 32'h0);

    // Coincident pre on every channel with post: LTP only, dt=0.
    expect_upd("coincident", 4'b1111, 4'b0, 8'd0, 16'hAAAA);
    spike(4'b1111, 1'b1);
    idle(20);

    // dt=16 is outside the window.
    do_reset();
    spike(4'b0001, 1'b0);
    idle(16);
    spike(4'b0000, 1'b1);
    chk("dt16_mask", 32'({ltp_mask, ltd_mask}), 32'h0);
    idle(20);
    chk("dt16_weights", 32'(weights), 32'h8888);

    // learn_en low freezes weights and masks.
    learn_en = 1'b0;
    spike(4'b0001, 1'b0);
    idle(2);
    spike(4'b0000, 1'b1);
    chk("frozen_mask", 32'({ltp_mask, ltd_mask, update_w_flag}), 32'h0);
    idle(20);
    learn_en = 1'b1;
    chk("frozen_weights", 32'(weights), 32'h8888);

    // Host write to channel 3 beats its LTP; channel 0 still learns.
    expect_upd("write_vs_ltp", 4'b1001, 4'b0, 8'd2, 16'h588A);
    spike(4'b1001, 1'b0);
    idle(2);
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 4'h5;
    spike(4'b0000, 1'b1);
    wr_en = 1'b0;
    idle(20);

    // Plain host write with no learning activity.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h3;
    idle(1);
    wr_en = 1'b0;
    chk("plain_write", 32'(weights), 32'h583A);
    chk("time_diff_hold", 32'(time_diff), 32'h2);
    idle(3);

    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
